// File: rtl/perif_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, baud divisor, status/control registers.
// Optional even/odd parity bit when PERIF_UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps

module perif_uart_tx #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_address,
  inout  wire  [63:0] mem_data,
  input  logic        select,
  input  logic        write_en,
  input  logic        read_en,
  input  logic [1:0]  size,
  output logic        tx,
  output logic        irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

`ifdef PERIF_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        r_state;
  logic          r_tx;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitIdx;
  logic [15:0]   r_baudCnt;
  logic [15:0]   r_divisor;
  logic          r_enable;
  logic          r_irqEn;
`ifdef PERIF_UART_TX_PARITY_EN
  logic          r_oddPar;
  logic          r_parBit;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic [1:0]    w_addr;
  logic          w_wr;
  logic          w_rd;
  logic          w_full;
  logic          w_empty;
  logic          w_pushReq;
  logic          w_push;
  logic          w_pop;
  logic          w_busy;
  logic [7:0]    w_popData;
  logic [63:0]   w_rdata;
  logic          w_unused;

  assign w_addr    = mem_address[4:3];
  assign w_wr      = select && write_en;
  assign w_rd      = select && read_en && !write_en;
  assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pushReq = w_wr && (w_addr == 2'd0);
  assign w_push    = w_pushReq && !w_full;
  assign w_pop     = (r_state == S_IDLE) && r_enable && !w_empty;
  assign w_busy    = (r_state != S_IDLE);
  assign w_popData = r_mem[r_rptr];
  assign w_unused  = ^{mem_address[31:5], mem_address[2:0], size, mem_data[63:16]};

  assign tx  = r_tx;
  assign irq = r_irqEn && w_empty && !w_busy;

  // Full comes from the registered count, so a push is dropped even when a pop happens alongside it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_pushReq && w_full)
        r_overflow <= 1'b1;
      else if (w_wr && (w_addr == 2'd1) && mem_data[3])
        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= mem_data[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_divisor <= DIV_RESET;
      r_enable  <= 1'b0;
      r_irqEn   <= 1'b0;
`ifdef PERIF_UART_TX_PARITY_EN
      r_oddPar  <= 1'b0;
`endif
    end else if (w_wr) begin
      if (w_addr == 2'd2) r_divisor <= mem_data[15:0];
      if (w_addr == 2'd3) begin
        r_enable <= mem_data[0];
        r_irqEn  <= mem_data[1];
`ifdef PERIF_UART_TX_PARITY_EN
        r_oddPar <= mem_data[2];
`endif
      end
    end
  end

  // The divisor is sampled only when a bit starts, so a rewrite never stretches or cuts the current bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_bitIdx  <= '0;
      r_baudCnt <= '0;
`ifdef PERIF_UART_TX_PARITY_EN
      r_parBit  <= 1'b0;
`endif
    end else begin
      if (r_state == S_IDLE) begin
        r_tx <= 1'b1;
        if (w_pop) begin
          r_shift   <= w_popData;
          r_bitIdx  <= 3'd7;
          r_baudCnt <= r_divisor;
          r_tx      <= 1'b0;
          r_state   <= S_START;
`ifdef PERIF_UART_TX_PARITY_EN
          r_parBit  <= (^w_popData) ^ r_oddPar;
`endif
        end
      end else if (r_baudCnt != 16'd0) begin
        r_baudCnt <= r_baudCnt - 16'd1;
      end else begin
        r_baudCnt <= r_divisor;
        case (r_state)
          S_START: begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_state <= S_DATA;
          end
          S_DATA: begin
            if (r_bitIdx == 3'd0) begin
`ifdef PERIF_UART_TX_PARITY_EN
              r_tx    <= r_parBit;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_tx     <= r_shift[0];
              r_shift  <= {1'b0, r_shift[7:1]};
              r_bitIdx <= r_bitIdx - 3'd1;
            end
          end
`ifdef PERIF_UART_TX_PARITY_EN
          S_PARITY: begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
`endif
          S_STOP: begin
            r_tx    <= 1'b1;
            r_state <= S_IDLE;
          end
          default: begin
            r_tx    <= 1'b1;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      2'd1: begin
        w_rdata[0]   = w_full;
        w_rdata[1]   = w_empty;
        w_rdata[2]   = w_busy;
        w_rdata[3]   = r_overflow;
        w_rdata[8:4] = 5'(r_count);
      end
      2'd2: w_rdata[15:0] = r_divisor;
      2'd3: begin
        w_rdata[0] = r_enable;
        w_rdata[1] = r_irqEn;
`ifdef PERIF_UART_TX_PARITY_EN
        w_rdata[2] = r_oddPar;
`endif
      end
      default: w_rdata = '0;
    endcase
  end

  assign mem_data = w_rd ? w_rdata : 64'bz;

endmodule

// File: tb/tb_perif_uart_tx.sv
// Directed bench for perif_uart_tx: register table, frame waveform checks, mid-frame
// enable/divisor changes and asynchronous reset during a frame.
`timescale 1ns/1ps

module tb_perif_uart_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_address = '0;
  wire  [63:0] mem_data;
  logic        select = 1'b0;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic [1:0]  size = 2'b11;
  logic        tx;
  logic        irq;
  logic        tbDrive = 1'b0;
  logic [63:0] tbData = '0;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic        isWrite;
    logic [1:0]  addr;
    logic [63:0] data;
    logic [63:0] expRead;
    logic        expIrq;
  } busVec_t;

  busVec_t vecs[22];

  assign mem_data = tbDrive ? tbData : 64'bz;

  always #5 clock = ~clock;

  perif_uart_tx #(.FIFO_DEPTH(4), .DIV_RESET(16'd433)) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .select      (select),
    .write_en    (write_en),
    .read_en     (read_en),
    .size        (size),
    .tx          (tx),
    .irq         (irq)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // While the bench drives a write, the DUT must leave the bus alone.
  task automatic busWrite(input logic [1:0] addr, input logic [63:0] data);
    @(negedge clock);
    mem_address = {27'd0, addr, 3'd0};
    tbData      = data;
    tbDrive     = 1'b1;
    select      = 1'b1;
    write_en    = 1'b1;
    #1 checkOutput("busNoDriveOnWrite", mem_data, data);
    @(posedge clock);
    #1;
    select   = 1'b0;
    write_en = 1'b0;
    tbDrive  = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [63:0] data);
    @(negedge clock);
    mem_address = {27'd0, addr, 3'd0};
    select      = 1'b1;
    read_en     = 1'b1;
    #1 data = mem_data;
    select  = 1'b0;
    read_en = 1'b0;
  endtask

  task automatic applyStimulus(input busVec_t v, input int idx);
    logic [63:0] rd;
    if (v.isWrite) begin
      busWrite(v.addr, v.data);
    end else begin
      busRead(v.addr, rd);
      checkOutput($sformatf("vec%0d_read", idx), rd, v.expRead);
      checkOutput($sformatf("vec%0d_irq", idx), 64'(irq), 64'(v.expIrq));
    end
  endtask

  // Walks one frame negedge by negedge against a model of the expected line.
  // midAt >= 0 performs one bus access at that offset from the start bit.
  task automatic runFrame(input logic [7:0] b, input int div0, input int expWait,
                          input int midAt, input logic midIsRead, input logic [1:0] midAddr,
                          input logic [63:0] midData, input string tag);
    logic [9:0] bits;
    int waited;
    int curDiv;
    int nextDiv;
    int offset;
    int badSamples;
    logic writeHeld;
    bits      = {1'b1, b, 1'b0};
    waited    = 0;
    offset    = 0;
    writeHeld = 1'b0;
    curDiv    = div0;
    @(negedge clock);
    while (tx !== 1'b0 && waited < 500) begin
      @(negedge clock);
      waited++;
    end
    if (tx !== 1'b0) begin
      checkOutput({tag, "_startTimeout"}, 64'(tx), 64'd0);
      return;
    end
    if (expWait >= 0) checkOutput({tag, "_latency"}, 64'(waited), 64'(expWait));
    for (int k = 0; k < 10; k++) begin
      badSamples = 0;
      nextDiv    = curDiv;
      for (int c = 0; c <= curDiv; c++) begin
        if (offset > 0) @(negedge clock);
        if (writeHeld) begin
          select    = 1'b0;
          write_en  = 1'b0;
          tbDrive   = 1'b0;
          writeHeld = 1'b0;
        end
        if (tx !== bits[k]) badSamples++;
        if (offset == midAt) begin
          mem_address = {27'd0, midAddr, 3'd0};
          select      = 1'b1;
          if (midIsRead) begin
            read_en = 1'b1;
            #1 checkOutput({tag, "_midRead"}, mem_data, midData);
            select  = 1'b0;
            read_en = 1'b0;
          end else begin
            tbData    = midData;
            tbDrive   = 1'b1;
            write_en  = 1'b1;
            writeHeld = 1'b1;
          end
        end
        if (c == curDiv && midAt >= 0 && !midIsRead && midAddr == 2'd2 && midAt < offset)
          nextDiv = int'(midData[15:0]);
        offset++;
      end
      checkOutput($sformatf("%s_bit%0d_badSamples", tag, k), 64'(badSamples), 64'd0);
      curDiv = nextDiv;
    end
  endtask

  task automatic checkIdleFor(input int cycles, input string tag);
    int lowSamples;
    lowSamples = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) lowSamples++;
    end
    checkOutput(tag, 64'(lowSamples), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rd;

    vecs[0]  = '{1'b0, 2'd1, 64'd0, 64'h2, 1'b0};
    vecs[1]  = '{1'b0, 2'd2, 64'd0, 64'd433, 1'b0};
    vecs[2]  = '{1'b0, 2'd3, 64'd0, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 64'd0, 64'h0, 1'b0};
    vecs[4]  = '{1'b1, 2'd2, 64'hFFFF_FFFF_FFFF_1234, 64'd0, 1'b0};
    vecs[5]  = '{1'b0, 2'd2, 64'd0, 64'h1234, 1'b0};
    vecs[6]  = '{1'b1, 2'd3, 64'h7, 64'd0, 1'b0};
    vecs[7]  = '{1'b0, 2'd3, 64'd0, 64'h3, 1'b1};
    vecs[8]  = '{1'b1, 2'd3, 64'h0, 64'd0, 1'b0};
    vecs[9]  = '{1'b0, 2'd3, 64'd0, 64'h0, 1'b0};
    vecs[10] = '{1'b1, 2'd2, 64'd3, 64'd0, 1'b0};
    vecs[11] = '{1'b0, 2'd2, 64'd0, 64'd3, 1'b0};
    vecs[12] = '{1'b1, 2'd0, 64'h11, 64'd0, 1'b0};
    vecs[13] = '{1'b0, 2'd1, 64'd0, 64'h10, 1'b0};
    vecs[14] = '{1'b1, 2'd0, 64'h22, 64'd0, 1'b0};
    vecs[15] = '{1'b1, 2'd0, 64'h33, 64'd0, 1'b0};
    vecs[16] = '{1'b1, 2'd0, 64'h44, 64'd0, 1'b0};
    vecs[17] = '{1'b0, 2'd1, 64'd0, 64'h41, 1'b0};
    vecs[18] = '{1'b1, 2'd0, 64'h55, 64'd0, 1'b0};
    vecs[19] = '{1'b0, 2'd1, 64'd0, 64'h49, 1'b0};
    vecs[20] = '{1'b1, 2'd1, 64'h8, 64'd0, 1'b0};
    vecs[21] = '{1'b0, 2'd1, 64'd0, 64'h41, 1'b0};

    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("resetTx", 64'(tx), 64'd1);
    checkOutput("resetIrq", 64'(irq), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 22; i++) applyStimulus(vecs[i], i);

    // Four queued bytes (the fifth was dropped) go out in order once enabled.
    busWrite(2'd3, 64'h3);
    runFrame(8'h11, 3, 1, 5, 1'b1, 2'd1, 64'h34, "f11");
    runFrame(8'h22, 3, 1, -1, 1'b0, 2'd0, 64'd0, "f22");
    runFrame(8'h33, 3, 1, -1, 1'b0, 2'd0, 64'd0, "f33");
    runFrame(8'h44, 3, 1, -1, 1'b0, 2'd0, 64'd0, "f44");
    @(negedge clock);
    checkOutput("afterBurstTx", 64'(tx), 64'd1);
    checkOutput("afterBurstIrq", 64'(irq), 64'd1);
    busRead(2'd1, rd);
    checkOutput("afterBurstStatus", rd, 64'h2);
    checkIdleFor(40, "noFifthFrame");

    busWrite(2'd0, 64'hA5);
    checkOutput("a5IrqQueued", 64'(irq), 64'd0);
    runFrame(8'hA5, 3, 1, -1, 1'b0, 2'd0, 64'd0, "fA5");
    @(negedge clock);
    checkOutput("a5IrqDone", 64'(irq), 64'd1);

    // Enable cleared during DATA: current frame finishes, queued byte waits.
    busWrite(2'd0, 64'h5A);
    busWrite(2'd0, 64'hC3);
    runFrame(8'h5A, 3, 0, 12, 1'b0, 2'd3, 64'h2, "f5A");
    checkIdleFor(40, "heldWhileDisabled");
    busRead(2'd1, rd);
    checkOutput("heldStatus", rd, 64'h10);
    checkOutput("heldIrq", 64'(irq), 64'd0);
    busWrite(2'd3, 64'h3);
    runFrame(8'hC3, 3, 1, -1, 1'b0, 2'd0, 64'd0, "fC3");

    // Divisor rewritten in the middle of bit 1: bit 2 onward uses the new period.
    busWrite(2'd0, 64'h96);
    runFrame(8'h96, 3, 1, 5, 1'b0, 2'd2, 64'd1, "f96");
    busRead(2'd2, rd);
    checkOutput("newDivisor", rd, 64'd1);

    // Reset in the middle of a frame of zeros forces the line high at once.
    busWrite(2'd0, 64'h00);
    busWrite(2'd0, 64'h00);
    repeat (3) @(negedge clock);
    checkOutput("preResetLow", 64'(tx), 64'd0);
    reset = 1'b0;
    #1 checkOutput("midFrameResetTx", 64'(tx), 64'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    busRead(2'd1, rd);
    checkOutput("postResetStatus", rd, 64'h2);
    busRead(2'd2, rd);
    checkOutput("postResetDivisor", rd, 64'd433);
    busRead(2'd3, rd);
    checkOutput("postResetControl", rd, 64'h0);
    checkIdleFor(30, "postResetIdle");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/perif_uart_tx.md
# perif_uart_tx

Memory-mapped UART transmitter that responds on the peripheral chip-select of the CPU memory bus, alongside the RAM and program ROM. The CPU writes bytes into a small transmit FIFO and polls status. A bit-timing FSM serialises each byte onto `tx` as 8N1 frames at a programmable baud divisor.

## Interface
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, 2–16.
- `DIV_RESET`, 16'd433: reset value of the DIVISOR register.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_address`  in  32  bus address; only `mem_address[4:3]` is decoded.
- `mem_data`  inout  64  bus data; driven only during reads, high-Z otherwise.
- `select`  in  1  peripheral chip-select from the bus decoder.
- `write_en`  in  1  write strobe, sampled on the rising edge when `select`=1.
- `read_en`  in  1  read strobe.
- `size`  in  2  access size; ignored, full 64-bit lanes are used.
- `tx`  out  1  serial output; idles high.
- `irq`  out  1  high while CONTROL.irq_en=1 and the FIFO is empty and the FSM is idle.

## Operation
- Register map (`mem_address[4:3]`):
  - 0 TXDATA: write pushes `mem_data[7:0]`; reads 0.
  - 1 STATUS: read-only except bit3.
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - bits[8:4] FIFO count.
    - Writing bit3=1 clears overflow.
  - 2 DIVISOR: bits[15:0]; bit period = DIVISOR+1 clocks.
  - 3 CONTROL: bit0 enable, bit1 irq_en.
  - Unused read bits are 0.
- Reads are combinational. `mem_data` is driven when `select`&&`read_en`, else high-Z. No drive during a write cycle.
- Push when full is dropped and sets overflow. Full is evaluated from the registered count, so the push is dropped even if a pop occurs in the same cycle.
- FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: `tx`=1. If enable=1 and FIFO non-empty, pop into the shift register, load the bit counter, and go to START.
  - START: `tx`=0 for one bit period.
  - DATA: 8 bits, LSB first, one bit period each.
  - STOP: `tx`=1 for one bit period. Then return to IDLE; the next frame may start on the following cycle.
- Clearing enable mid-frame: the current frame completes, then the FSM holds in IDLE.
- DIVISOR write mid-frame: takes effect at the next bit boundary, not mid-bit.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. The count is one bit wider.

## Timing
- Reset values:
  - `tx`=1, `irq`=0, FSM=IDLE.
  - FIFO empty, count=0, overflow=0.
  - DIVISOR=DIV_RESET, CONTROL=0.
  - `mem_data` high-Z.
- Reset asserted mid-frame: `tx` goes to 1 immediately and asynchronously. The FIFO is cleared and the frame is lost.
- Write at edge N: count increments after N.
- With enable=1 and the FSM idle, the pop occurs at edge N+1 and `tx` falls after N+1.
- Frame length: 10×(DIVISOR+1) clocks; 11× with parity.
- Back-to-back frames: one IDLE cycle between STOP end and the next START.
- STATUS reflects register state after the latest edge; there is no read latency.

## Configuration
- `PERIF_UART_TX_PARITY_EN`:
  - Defined: adds a PARITY state between DATA and STOP, transmitting even parity of the 8 data bits for one bit period. CONTROL bit2 selects odd parity when 1.
  - Undefined: 8N1 only; CONTROL bit2 reads 0.

## Test plan
- Reset: assert `reset`=0 mid-frame → `tx`=1 immediately; STATUS reads 0x2 (empty); DIVISOR reads 433.
- Single byte: DIVISOR=3, enable=1, write 0xA5 → `tx` shows start 0, bits 1,0,1,0,0,1,0,1, stop 1. Each bit lasts 4 clocks; 40 clocks total; then `irq`=1 if irq_en=1.
- Overflow: enable=0, write 5 bytes with depth 4 → STATUS count=4, full=1, overflow=1. Writing STATUS bit3=1 clears overflow. After enable, exactly 4 bytes are sent in order.
- Bus behaviour: `mem_data` is high-Z when `select`=0 or during writes. Reading DIVISOR after writing 0x1234 returns 0x...0001234.
- Mid-frame changes: clear enable during DATA → the frame completes and the next queued byte is held. Change DIVISOR mid-bit → the new period applies from the next bit.
- Parity (macro defined): send 0x07, even parity → parity bit 1, frame length 11×(DIVISOR+1) clocks.
